switch_bank: RTL and testbench
==============================

# switch_bank

Parametrised multi-channel input conditioner for the Computer top level. Synchronises, debounces and edge-detects up to 32 raw switch/button inputs. Presents stable levels zero-extended to the 32-bit lever word read by RAMmanager, plus per-channel rise/fall pulses and a sticky event register that the CPU clears with write-1-to-clear. Replaces the fixed bank of eight single-channel Cleaner instances.

## Interface
Parameters:
- `CHANNELS`, default 8: number of inputs, legal range 1..32.
- `DEBOUNCE_BITS`, default 16: debounce counter width. `MAX` = 2^DEBOUNCE_BITS − 1.
- `SYNC_STAGES`, default 2: synchroniser depth, legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  CHANNELS  raw asynchronous inputs.
- `level`  out  32  debounced stable levels; bits [31:CHANNELS] are tied to 0.
- `rise`  out  CHANNELS  one-cycle pulse when a stable level goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when a stable level goes 1→0.
- `events`  out  32  sticky change flags; bits [31:CHANNELS] are 0.
- `clr_we`  in  1  strobe that applies `clr_mask`.
- `clr_mask`  in  32  write-1-to-clear mask for `events`.
- `irq_mask_we`, `irq_mask_data` (in 1 / in 32), `irq` (out 1): present only with `SWITCH_BANK_IRQ_EN`.

## Operation
- Per channel: a `SYNC_STAGES`-deep flop chain produces `s`. A stable register `st` drives `level`. A counter `cnt` of width `DEBOUNCE_BITS` tracks mismatches.
- When `s == st`: `cnt <= 0`.
- When `s != st` and `cnt != MAX`: `cnt <= cnt + 1`.
- When `s != st` and `cnt == MAX`: `st <= s` and `cnt <= 0`. This is the only way `st` changes, so a change needs MAX+1 consecutive mismatching cycles.
- Any return to a match before MAX+1 cycles discards the count; there is no partial credit.
- `rise[i]` / `fall[i]` are registered. They are high for exactly the one cycle in which `st[i]` holds its new value.
- `events[i]` is set on the same edge that `st[i]` changes (either direction).
- On `clr_we`, every `events[i]` with `clr_mask[i]=1` is cleared.
- If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Mask bits ≥ CHANNELS are ignored.
- Channels are fully independent; simultaneous changes on several channels are all captured.
- Reset values: sync chains 0, `st` 0, `cnt` 0, `level` 0, `rise` 0, `fall` 0, `events` 0, `irq` 0, irq mask 0.
- Reset mid-count drops all progress. After release, an input held at 1 needs the full latency again.

## Timing
- Latency from a `sig_in[i]` change (held steady) to `level[i]` change is SYNC_STAGES + MAX + 1 cycles.
- `rise`/`fall`/`events` assert on the same edge as `level`.
- A clear applied with `clr_we` in cycle n is visible in `events` in cycle n+1.
- `level` is the value of `st` with no extra register stage.
- There is no combinational path from `sig_in`, `clr_*` or `irq_mask_*` to any output.

## Configuration
- `SWITCH_BANK_IRQ_EN` defined:
  - Adds a 32-bit irq mask register, loaded from `irq_mask_data` when `irq_mask_we` is high.
  - Adds a registered `irq` output: `irq <= |(events_next & mask_next)`, where both operands are the values being written this cycle. `irq` therefore rises on the same edge as the triggering `events` bit and falls on the edge that clears it.
- Not defined: the mask register and the `irq_mask_we`, `irq_mask_data` and `irq` ports do not exist. No irq logic is synthesised.

## Test plan
All scenarios use CHANNELS=8, DEBOUNCE_BITS=2 (MAX=3), SYNC_STAGES=2 unless stated.
- **Reset:** hold `rst` 3 cycles with `sig_in`=0xFF → `level`=0, `events`=0, `rise`=`fall`=0. After release, `level` becomes 0x000000FF exactly 6 cycles later, and `rise`=0xFF for one cycle.
- **Single press:** `sig_in[0]` 0→1 and held → `level`[0]=1 on cycle 6, `rise[0]` pulses once, `events`=0x00000001. Release → `fall[0]` pulses 6 cycles later, and `events` remains 0x1.
- **Glitch rejection:** `sig_in[3]` high for 3 cycles then low → `level`, `rise` and `events` never change. A 4-cycle-high run (as seen at `s`) does change `level[3]`.
- **Clear race:** `events`=0x01; assert `clr_we` with `clr_mask`=0xFFFFFFFF on the same cycle `level[0]` toggles → `events` stays 0x01. Clear again one cycle later → `events`=0.
- **Width/reset mid-count:** CHANNELS=5 with `sig_in`=0x1F held → `level`=0x0000001F and bits [31:5] stay 0 throughout. Pulsing `rst` at cycle 4 → `level` first becomes 0x1F 6 cycles after reset release.
- **IRQ** (with `SWITCH_BANK_IRQ_EN`): write irq mask 0x02, toggle channel 0 → `irq`=0. Toggle channel 1 → `irq`=1 on the same edge `events[1]` sets. Clear bit 1 → `irq`=0 the next cycle.

Source files
------------

// File: rtl/switch_bank.sv
// switch_bank: multi-channel input conditioner.
// Each channel synchronises a raw asynchronous input and debounces it. A
// channel's stable level changes only after MAX+1 consecutive cycles in which
// the synchronised input disagrees with it. The block drives the stable
// levels, one-cycle rise/fall pulses and sticky write-1-to-clear event flags.
//
// Optional feature macro: SWITCH_BANK_IRQ_EN (adds irq mask register + irq).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   sig_in         [CHANNELS] raw asynchronous inputs
//   level          [32] debounced levels, bits above CHANNELS are 0
//   rise, fall     [CHANNELS] one-cycle edge pulses of the stable level
//   events         [32] sticky change flags, bits above CHANNELS are 0
//   clr_we         strobe that applies clr_mask
//   clr_mask       [32] write-1-to-clear mask for events
//   irq_mask_we    (irq build) load strobe for the irq mask
//   irq_mask_data  (irq build) [32] new irq mask
//   irq            (irq build) registered |(events & mask)

// One debounced channel.
module switch_bank_lane #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic st_o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_o      // stable level flips on the coming edge
);
    localparam logic [DEBOUNCE_BITS-1:0] MAX = '1;

    logic [SYNC_STAGES-1:0]   sync_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     st_q, rise_q, fall_q;
    logic                     s, chg;

    assign s   = sync_q[SYNC_STAGES-1];
    // Full run of mismatches seen: take the new value now.
    assign chg = (s != st_q) && (cnt_q == MAX);

    // Any match discards the count; a completed run also restarts from zero.
    always_comb begin
        cnt_d = '0;
        if ((s != st_q) && (cnt_q != MAX))
            cnt_d = cnt_q + DEBOUNCE_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            st_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            cnt_q  <= cnt_d;
            if (chg)
                st_q <= s;
            rise_q <= chg & s;
            fall_q <= chg & ~s;
        end
    end

    assign st_o   = st_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = chg;
endmodule

module switch_bank #(
    parameter int CHANNELS      = 8,
    parameter int DEBOUNCE_BITS = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [31:0]         level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [31:0]         events,
    input  logic                clr_we,
    input  logic [31:0]         clr_mask
`ifdef SWITCH_BANK_IRQ_EN
    ,
    input  logic                irq_mask_we,
    input  logic [31:0]         irq_mask_data,
    output logic                irq
`endif
);
    logic [CHANNELS-1:0] st_vec, chg_vec;
    logic [31:0]         events_q, events_d, clr_eff;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        switch_bank_lane #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .sig_i (sig_in[i]),
            .st_o  (st_vec[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i]),
            .chg_o (chg_vec[i])
        );
    end

    // Events are kept 32 wide; bits at and above CHANNELS are never set, so
    // mask bits there have nothing to act on. Set is OR'd after the clear so
    // a simultaneous set wins.
    assign clr_eff  = clr_we ? clr_mask : 32'h0;
    assign events_d = (events_q & ~clr_eff) | 32'(chg_vec);

    always_ff @(posedge clk) begin
        if (rst)
            events_q <= '0;
        else
            events_q <= events_d;
    end

    assign level  = 32'(st_vec);
    assign events = events_q;

`ifdef SWITCH_BANK_IRQ_EN
    logic [31:0] mask_q, mask_d;
    logic        irq_q;

    assign mask_d = irq_mask_we ? irq_mask_data : mask_q;

    // Built from next-state values so irq tracks events on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(events_d & mask_d);
        end
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_switch_bank.sv
module tb_switch_bank;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 8 channels, MAX=3
    logic        rst_a = 1'b1;
    logic [7:0]  sig_a = 8'h00;
    logic [31:0] level_a, events_a;
    logic [7:0]  rise_a, fall_a;
    logic        clr_we_a = 1'b0;
    logic [31:0] clr_mask_a = 32'h0;

    // DUT B: 5 channels, MAX=3
    logic        rst_b = 1'b1;
    logic [4:0]  sig_b = 5'h00;
    logic [31:0] level_b, events_b;
    logic [4:0]  rise_b, fall_b;

`ifdef SWITCH_BANK_IRQ_EN
    logic        irq_we_a = 1'b0;
    logic [31:0] irq_data_a = 32'h0;
    logic        irq_a;
    logic        irq_b;
`endif

    switch_bank #(.CHANNELS(8), .DEBOUNCE_BITS(2), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .sig_in(sig_a), .level(level_a),
        .rise(rise_a), .fall(fall_a), .events(events_a),
        .clr_we(clr_we_a), .clr_mask(clr_mask_a)
`ifdef SWITCH_BANK_IRQ_EN
        , .irq_mask_we(irq_we_a), .irq_mask_data(irq_data_a), .irq(irq_a)
`endif
    );

    switch_bank #(.CHANNELS(5), .DEBOUNCE_BITS(2), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .sig_in(sig_b), .level(level_b),
        .rise(rise_b), .fall(fall_b), .events(events_b),
        .clr_we(1'b0), .clr_mask(32'h0)
`ifdef SWITCH_BANK_IRQ_EN
        , .irq_mask_we(1'b0), .irq_mask_data(32'h0), .irq(irq_b)
`endif
    );

    typedef struct {
        logic        rst;
        logic [7:0]  sig;
        logic        we;
        logic [31:0] mask;
        logic [31:0] lvl;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [31:0] ev;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input int n, input logic r, input logic [7:0] s,
                       input logic we, input logic [31:0] m, input logic [31:0] l,
                       input logic [7:0] ri, input logic [7:0] fa, input logic [31:0] ev);
        vec_t v;
        v.rst = r; v.sig = s; v.we = we; v.mask = m;
        v.lvl = l; v.rise = ri; v.fall = fa; v.ev = ev;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held 3 cycles with all inputs high
        add(3, 1, 8'hFF, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h00);
        add(5, 0, 8'hFF, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h00);
        add(1, 0, 8'hFF, 0, 32'h0, 32'hFF, 8'hFF, 8'h00, 32'hFF);
        add(1, 0, 8'hFF, 0, 32'h0, 32'hFF, 8'h00, 8'h00, 32'hFF);
        // all released together
        add(5, 0, 8'h00, 0, 32'h0, 32'hFF, 8'h00, 8'h00, 32'hFF);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'hFF, 32'hFF);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'hFF);
        add(1, 0, 8'h00, 1, 32'hFFFFFFFF, 32'h00, 8'h00, 8'h00, 32'h00);
        // single press / release on channel 0
        add(5, 0, 8'h01, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h00);
        add(1, 0, 8'h01, 0, 32'h0, 32'h01, 8'h01, 8'h00, 32'h01);
        add(2, 0, 8'h01, 0, 32'h0, 32'h01, 8'h00, 8'h00, 32'h01);
        add(5, 0, 8'h00, 0, 32'h0, 32'h01, 8'h00, 8'h00, 32'h01);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h01, 32'h01);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        // 3-cycle glitch on channel 3: rejected
        add(3, 0, 8'h08, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        add(6, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        // 4-cycle pulse on channel 3: accepted, then debounced back low
        add(4, 0, 8'h08, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        add(1, 0, 8'h00, 0, 32'h0, 32'h08, 8'h08, 8'h00, 32'h09);
        add(3, 0, 8'h00, 0, 32'h0, 32'h08, 8'h00, 8'h00, 32'h09);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h08, 32'h09);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h09);
        // mask without strobe does nothing; partial clear incl. out-of-range bit
        add(1, 0, 8'h00, 0, 32'hFFFFFFFF, 32'h00, 8'h00, 8'h00, 32'h09);
        add(1, 0, 8'h00, 1, 32'h00000108, 32'h00, 8'h00, 8'h00, 32'h01);
        // clear race: set and clear on the same edge, set wins
        add(5, 0, 8'h01, 0, 32'h0, 32'h00, 8'h00, 8'h00, 32'h01);
        add(1, 0, 8'h01, 1, 32'hFFFFFFFF, 32'h01, 8'h01, 8'h00, 32'h01);
        add(1, 0, 8'h01, 1, 32'hFFFFFFFF, 32'h01, 8'h00, 8'h00, 32'h00);
        add(5, 0, 8'h00, 0, 32'h0, 32'h01, 8'h00, 8'h00, 32'h00);
        add(1, 0, 8'h00, 0, 32'h0, 32'h00, 8'h00, 8'h01, 32'h01);
        add(1, 0, 8'h00, 1, 32'hFFFFFFFF, 32'h00, 8'h00, 8'h00, 32'h00);

        foreach (tbl[k]) begin
            rst_a = tbl[k].rst; sig_a = tbl[k].sig;
            clr_we_a = tbl[k].we; clr_mask_a = tbl[k].mask;
            tick();
            chk($sformatf("v%0d level", k),  level_a,  tbl[k].lvl);
            chk($sformatf("v%0d rise", k),   rise_a,   tbl[k].rise);
            chk($sformatf("v%0d fall", k),   fall_a,   tbl[k].fall);
            chk($sformatf("v%0d events", k), events_a, tbl[k].ev);
`ifdef SWITCH_BANK_IRQ_EN
            chk($sformatf("v%0d irq", k), irq_a, 1'b0);
`endif
        end
        clr_we_a = 1'b0; clr_mask_a = 32'h0;

        // 5-channel instance: reset mid-count, then full latency again
        rst_b = 1'b1; sig_b = 5'h1F;
        tick(); tick();
        chk("b reset level", level_b, 32'h0);
        rst_b = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("b pre c%0d level", i), level_b, 32'h0);
        end
        rst_b = 1'b1;
        tick();
        chk("b midreset level", level_b, 32'h0);
        chk("b midreset events", events_b, 32'h0);
        rst_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("b post c%0d level", i), level_b, 32'h0);
        end
        tick();
        chk("b c6 level", level_b, 32'h1F);
        chk("b c6 rise", rise_b, 32'h1F);
        chk("b c6 events", events_b, 32'h1F);
        tick();
        chk("b c7 level", level_b, 32'h1F);
        chk("b c7 rise", rise_b, 32'h0);
        chk("b c7 fall", fall_b, 32'h0);

`ifdef SWITCH_BANK_IRQ_EN
        // irq: mask channel 1 only
        irq_we_a = 1'b1; irq_data_a = 32'h02;
        tick();
        irq_we_a = 1'b0;
        chk("irq after mask", irq_a, 1'b0);
        sig_a = 8'h01;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("irq ch0 c%0d", i), irq_a, 1'b0);
        end
        chk("irq ch0 events", events_a, 32'h01);
        sig_a = 8'h03;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("irq ch1 c%0d", i), irq_a, 1'b0);
        end
        tick();
        chk("irq ch1 events", events_a, 32'h03);
        chk("irq ch1 set", irq_a, 1'b1);
        clr_we_a = 1'b1; clr_mask_a = 32'h02;
        tick();
        clr_we_a = 1'b0; clr_mask_a = 32'h0;
        chk("irq clr events", events_a, 32'h01);
        chk("irq clr", irq_a, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
